// File: rtl/scariv_fpu_done_merger.sv
// scariv_fpu_done_merger: merges the FPU mv/fpnew done reports into one ordered ROB stream via a FIFO.
// SCARIV_FPU_DONE_BYPASS_EN enables a 0-cycle bypass when the FIFO is empty and the ROB is ready.
module scariv_fpu_done_merger #(
  parameter int DEPTH      = 8,
  parameter int CMT_ID_W   = 6,
  parameter int GRP_ID_W   = 5,
  parameter int EXC_W      = 6,
  parameter int STALL_FREE = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_mv_valid,
  input  logic [CMT_ID_W-1:0] i_mv_cmt_id,
  input  logic [GRP_ID_W-1:0] i_mv_grp_id,
  input  logic [EXC_W-1:0]    i_mv_exc,
  input  logic                i_fp_valid,
  input  logic [CMT_ID_W-1:0] i_fp_cmt_id,
  input  logic [GRP_ID_W-1:0] i_fp_grp_id,
  input  logic [EXC_W-1:0]    i_fp_exc,
  input  logic                i_flush,
  output logic                o_done_valid,
  input  logic                i_done_ready,
  output logic [CMT_ID_W-1:0] o_done_cmt_id,
  output logic [GRP_ID_W-1:0] o_done_grp_id,
  output logic [EXC_W-1:0]    o_done_exc,
  output logic                o_stall,
  output logic                o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = CMT_ID_W + GRP_ID_W + EXC_W;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
  logic [AW+1:0] avail;
  logic [AW-1:0] wa_fp, wa_mv;
  logic [EW-1:0] fp_ent, mv_ent, head, byp_ent;
  logic head_vld, pop, in_fp, in_mv, acc_fp, acc_mv, drop, stall_d, stall_q, ovf_q;
  logic byp, byp_fp, byp_mv;
  assign fp_ent = {i_fp_cmt_id, i_fp_grp_id, i_fp_exc};
  assign mv_ent = {i_mv_cmt_id, i_mv_grp_id, i_mv_exc};
  assign head_vld = cnt_q != '0;
`ifdef SCARIV_FPU_DONE_BYPASS_EN
  // fp is older, so it takes the bypass when both fire and mv queues behind it
  assign byp = !head_vld && i_done_ready && (i_fp_valid || i_mv_valid) && !i_flush;
  assign byp_fp = byp && i_fp_valid;
  assign byp_mv = byp && !i_fp_valid;
  assign byp_ent = byp_fp ? fp_ent : mv_ent;
`else
  assign byp = 1'b0;
  assign byp_fp = 1'b0;
  assign byp_mv = 1'b0;
  assign byp_ent = '0;
`endif
  always_comb begin
    head = mem_q[rd_q[AW-1:0]];
    pop = head_vld && i_done_ready;
    in_fp = i_fp_valid && !byp_fp && !i_flush;
    in_mv = i_mv_valid && !byp_mv && !i_flush;
    avail = (AW+2)'(DEPTH) - (AW+2)'(cnt_q) + (AW+2)'(pop);
    acc_fp = in_fp && avail != '0;
    acc_mv = in_mv && avail > (AW+2)'(acc_fp);
    drop = (in_fp && !acc_fp) || (in_mv && !acc_mv);
    wa_fp = wr_q[AW-1:0];
    wa_mv = wa_fp + AW'(acc_fp);
    wr_d = i_flush ? wr_q : wr_q + (AW+1)'(acc_fp) + (AW+1)'(acc_mv);
    rd_d = i_flush ? wr_q : rd_q + (AW+1)'(pop);
    cnt_d = i_flush ? '0 : cnt_q + (AW+1)'(acc_fp) + (AW+1)'(acc_mv) - (AW+1)'(pop);
    stall_d = ((AW+2)'(DEPTH) - (AW+2)'(cnt_d)) < (AW+2)'(STALL_FREE);
    o_done_valid = head_vld || byp;
    {o_done_cmt_id, o_done_grp_id, o_done_exc} = byp ? byp_ent : head_vld ? head : '0;
    o_stall = stall_q;
    o_overflow = ovf_q;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      stall_q <= 1'b0;
      ovf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      stall_q <= stall_d;
      ovf_q <= ovf_q | drop;
      if (acc_fp) mem_q[wa_fp] <= fp_ent;
      if (acc_mv) mem_q[wa_mv] <= mv_ent;
    end
  end
`ifdef SIMULATION
  always_ff @(posedge i_clk) if (i_reset_n && drop) $error("scariv_fpu_done_merger: done report dropped");
`endif
endmodule

// File: tb/tb_scariv_fpu_done_merger.sv
// tb_scariv_fpu_done_merger: scoreboard bench for the FPU done merger (default, non-bypass build).
module tb_scariv_fpu_done_merger;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mv_v = 0, fp_v = 0, flush = 0, rdy = 0;
  logic [5:0] mv_c = 0, fp_c = 0, mv_e = 0, fp_e = 0, o_c, o_e;
  logic [4:0] mv_g = 0, fp_g = 0, o_g;
  logic o_v, o_stall, o_ovf;
  always #5 clk = ~clk;
  scariv_fpu_done_merger dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_mv_valid(mv_v), .i_mv_cmt_id(mv_c), .i_mv_grp_id(mv_g), .i_mv_exc(mv_e),
    .i_fp_valid(fp_v), .i_fp_cmt_id(fp_c), .i_fp_grp_id(fp_g), .i_fp_exc(fp_e),
    .i_flush(flush), .o_done_valid(o_v), .i_done_ready(rdy),
    .o_done_cmt_id(o_c), .o_done_grp_id(o_g), .o_done_exc(o_e),
    .o_stall(o_stall), .o_overflow(o_ovf)
  );
  typedef struct packed {logic [5:0] c; logic [4:0] g; logic [5:0] e;} ent_t;
  ent_t sb[$];
  int errs = 0, checks = 0, npend = 0, nid = 60;
  bit flush_prev = 0, stall_nxt = 0, ovf_nxt = 0, exp_stall = 0, exp_ovf = 0, mon_en = 0;
  function automatic ent_t mk(logic [5:0] c);
    return '{c: c, g: c[4:0] + 5'd7, e: {c[0], ~c[4:0]}};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // one clock of stimulus; the model decides acceptance from free space as seen this cycle
  task automatic cyc(bit fv, logic [5:0] fc, bit mv, logic [5:0] mc, bit r, bit fl = 0);
    int size, avail, cnt_next;
    bit pop;
    ent_t f, m;
    @(posedge clk); #1;
    if (flush_prev) sb.delete();
    npend = 0;
    exp_stall = stall_nxt;
    exp_ovf = ovf_nxt;
    f = mk(fc);
    m = mk(mc);
    fp_v = fv; fp_c = f.c; fp_g = f.g; fp_e = f.e;
    mv_v = mv; mv_c = m.c; mv_g = m.g; mv_e = m.e;
    rdy = r; flush = fl;
    size = sb.size();
    pop = size != 0 && r;
    avail = 8 - size + int'(pop);
    if (!fl) begin
      if (fv && avail > 0) begin sb.push_back(f); avail--; npend++; end
      else if (fv) ovf_nxt = 1;
      if (mv && avail > 0) begin sb.push_back(m); avail--; npend++; end
      else if (mv) ovf_nxt = 1;
    end
    cnt_next = fl ? 0 : size - int'(pop) + npend;
    stall_nxt = (8 - cnt_next) < 4;
    flush_prev = fl;
  endtask
  always @(negedge clk) begin
    ent_t e;
    if (mon_en) begin
      chk("valid", o_v, (sb.size() - npend) != 0);
      chk("stall", o_stall, exp_stall);
      chk("overflow", o_ovf, exp_ovf);
      if (o_v && rdy) begin
        if (sb.size() == npend) begin
          checks++; errs++;
          $display("FAIL pop: got cmt %0d expected no report at %0t", o_c, $time);
        end else begin
          e = sb.pop_front();
          chk("cmt", o_c, e.c);
          chk("grp", o_g, e.g);
          chk("exc", o_e, e.e);
        end
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_v, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_cmt", o_c, 0);
    rst_n = 1;
    mon_en = 1;
    // single report: 1-cycle latency, then empty again
    cyc(1, 5, 0, 0, 1);
    @(negedge clk) chk("t1_lat", o_v, 0);
    cyc(0, 0, 0, 0, 1);
    @(negedge clk) chk("t1_cmt", o_c, 5);
    cyc(0, 0, 0, 0, 1);
    @(negedge clk) chk("t1_empty", o_v, 0);
    // dual push: fp first, then mv
    cyc(1, 3, 1, 4, 1);
    cyc(0, 0, 0, 0, 1);
    @(negedge clk) chk("t2_first", o_c, 3);
    cyc(0, 0, 0, 0, 1);
    @(negedge clk) chk("t2_second", o_c, 4);
    cyc(0, 0, 0, 0, 1);
    // fill to 6 while stalled downstream, watch o_stall rise then fall while draining
    for (int i = 0; i < 3; i++) cyc(1, 6'(10 + 2 * i), 1, 6'(11 + 2 * i), 0);
    @(negedge clk) chk("t3_stall_at4", o_stall, 0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk) chk("t3_stall_at6", o_stall, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    @(negedge clk) chk("t3_stall_at5", o_stall, 1);
    cyc(0, 0, 0, 0, 1);
    @(negedge clk) chk("t3_stall_at4b", o_stall, 0);
    repeat (4) cyc(0, 0, 0, 0, 1);
    @(negedge clk) chk("t3_drained", o_v, 0);
    // fill to 8, then one more is dropped
    for (int i = 0; i < 4; i++) cyc(1, 6'(20 + 2 * i), 1, 6'(21 + 2 * i), 0);
    cyc(1, 28, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk) begin
      chk("t4_ovf", o_ovf, 1);
      chk("t4_head", o_c, 20);
      chk("t4_stall", o_stall, 1);
    end
    // full with pop: fp takes the freed slot, mv dropped
    cyc(1, 30, 1, 31, 1);
    repeat (3) cyc(0, 0, 0, 0, 1);
    // five entries left; flush with a same-cycle fp report
    cyc(1, 40, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    @(negedge clk) begin
      chk("t5_valid", o_v, 0);
      chk("t5_stall", o_stall, 0);
      chk("t5_ovf", o_ovf, 1);
    end
    // random traffic to exercise pointer wrap against scoreboard order
    for (int i = 0; i < 20; i++) begin
      cyc($urandom_range(0, 1), 6'(nid), $urandom_range(0, 1), 6'(nid + 1), $urandom_range(0, 3) != 0);
      nid = (nid + 2) % 64;
    end
    repeat (10) cyc(0, 0, 0, 0, 1);
    @(negedge clk) chk("t6_drained", o_v, 0);
    // reset while holding entries discards them immediately
    cyc(1, 50, 1, 51, 0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    mon_en = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", o_v, 0);
    chk("mid_rst_ovf", o_ovf, 0);
    chk("mid_rst_stall", o_stall, 0);
    sb.delete();
    npend = 0; flush_prev = 0; stall_nxt = 0; ovf_nxt = 0; exp_stall = 0; exp_ovf = 0;
    @(posedge clk); #1;
    rst_n = 1;
    mon_en = 1;
    cyc(0, 0, 0, 0, 1);
    cyc(1, 7, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 1);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
